// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types and sizes for the MMU feeder.
// State encoding and lane geometry.
package mmu_pkg;

  localparam int LANES = 4;
  localparam int DW = 8;
  localparam int ROW_W = LANES * DW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_WT = 2'd1,
    STREAM  = 2'd2,
    FLUSH   = 2'd3
  } state_t;

endpackage

// File: rtl/skew_delay.sv
// skew_delay: reset-to-zero shift register.
// Output is the input delayed DEPTH cycles.
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] sr [DEPTH];

  // shift one stage per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/mmu_feeder.sv
// mmu_feeder: loads weights into the 4x4 MMU and
// streams diagonally skewed activation rows.
module mmu_feeder
  import mmu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wt_valid,
  output logic                wt_ready,
  input  logic [LANES*DW-1:0] wt_in,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic [LANES*DW-1:0] x_in,
  input  logic                x_last,
  output logic                control,
  output logic [LANES*DW-1:0] wt_arr,
  output logic [LANES*DW-1:0] data_arr,
  output logic                busy,
  output logic                done
);

  localparam int CW = (LANES > 2) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] WT_LAST = CW'(LANES - 1);
  localparam logic [CW-1:0] FL_LAST = CW'(LANES - 2);

  state_t        state, state_d;
  logic [CW-1:0] wt_cnt, wt_cnt_d;
  logic [CW-1:0] fl_cnt, fl_cnt_d;
  logic          done_d;
  logic          wt_acc, x_acc;
  logic [LANES*DW-1:0] feed;

  assign wt_acc = wt_valid && wt_ready;
  assign x_acc  = x_valid && x_ready;
  assign feed   = x_acc ? x_in : '0;
  assign busy   = (state != IDLE);

  // state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wt_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      state  <= state_d;
      wt_cnt <= wt_cnt_d;
      fl_cnt <= fl_cnt_d;
    end
  end

  // next state, counters and done
  always_comb begin
    state_d  = state;
    wt_cnt_d = wt_cnt;
    fl_cnt_d = fl_cnt;
    done_d   = 1'b0;
    unique case (state)
      IDLE, LOAD_WT: begin
        if (wt_acc) begin
          if (wt_cnt == WT_LAST) begin
            wt_cnt_d = '0;
            state_d  = STREAM;
          end else begin
            wt_cnt_d = wt_cnt + 1'b1;
            state_d  = LOAD_WT;
          end
        end
      end
      STREAM: begin
        if (x_acc && x_last) begin
          fl_cnt_d = '0;
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        if (fl_cnt == FL_LAST) begin
          fl_cnt_d = '0;
          state_d  = IDLE;
          done_d   = 1'b1;
        end else begin
          fl_cnt_d = fl_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // registered handshakes, weight drive and done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control  <= 1'b0;
      wt_arr   <= '0;
      done     <= 1'b0;
      wt_ready <= 1'b0;
      x_ready  <= 1'b0;
    end else begin
      control  <= wt_acc;
      if (wt_acc)
        wt_arr <= wt_in;
      done     <= done_d;
      wt_ready <= (state_d == IDLE) ||
                  (state_d == LOAD_WT);
      x_ready  <= (state_d == STREAM);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_delay #(
      .DEPTH(k + 1),
      .DW   (DW)
    ) u_dly (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (feed[k*DW +: DW]),
      .q    (data_arr[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_mmu_feeder.sv
// tb_mmu_feeder: directed and random checks of mmu_feeder
// against a cycle-level reference model.
module tb_mmu_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wt_valid;
  logic        wt_ready;
  logic [31:0] wt_in;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] x_in;
  logic        x_last;
  logic        control;
  logic [31:0] wt_arr;
  logic [31:0] data_arr;
  logic        busy;
  logic        done;

  mmu_feeder #(.LANES(4), .DW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wt_valid(wt_valid),
    .wt_ready(wt_ready),
    .wt_in   (wt_in),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_in    (x_in),
    .x_last  (x_last),
    .control (control),
    .wt_arr  (wt_arr),
    .data_arr(data_arr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: phase 0 = loading weights,
  // 1 = streaming rows, 2 = draining the skew
  int          m_phase;
  int          m_wcnt;
  int          m_fleft;
  bit          m_wrdy;
  bit          m_xrdy;
  bit          m_ctrl;
  bit          m_done;
  logic [31:0] m_wt;
  logic [31:0] hist[$];

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%h exp=%h",
                tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_wcnt  = 0;
    m_fleft = 0;
    m_wrdy  = 1'b0;
    m_xrdy  = 1'b0;
    m_ctrl  = 1'b0;
    m_done  = 1'b0;
    m_wt    = '0;
    hist.delete();
  endtask

  function automatic logic [31:0] exp_data();
    logic [31:0] e;
    logic [31:0] r;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      if (hist.size() > k) begin
        r = hist[hist.size() - 1 - k];
        e[k*8 +: 8] = r[k*8 +: 8];
      end
    end
    return e;
  endfunction

  // one clock: advance model, then compare at negedge
  task automatic step();
    bit          wacc;
    bit          xacc;
    logic [31:0] fed;
    wacc = wt_valid && m_wrdy;
    xacc = x_valid && m_xrdy;
    fed  = xacc ? x_in : 32'h0;
    m_ctrl = wacc;
    m_done = 1'b0;
    if (wacc) m_wt = wt_in;
    if (m_phase == 0 && wacc) begin
      m_wcnt++;
      if (m_wcnt == 4) begin
        m_wcnt  = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1 && xacc && x_last) begin
      m_phase = 2;
      m_fleft = 3;
    end else if (m_phase == 2) begin
      m_fleft--;
      if (m_fleft == 0) begin
        m_phase = 0;
        m_done  = 1'b1;
      end
    end
    m_wrdy = (m_phase == 0);
    m_xrdy = (m_phase == 1);
    hist.push_back(fed);
    if (hist.size() > 8) void'(hist.pop_front());
    @(posedge clk);
    @(negedge clk);
    check("data_arr", data_arr, exp_data());
    check("control", 32'(control), 32'(m_ctrl));
    check("wt_arr", wt_arr, m_wt);
    check("done", 32'(done), 32'(m_done));
    check("busy", 32'(busy),
          32'(!(m_phase == 0 && m_wcnt == 0)));
    check("wt_ready", 32'(wt_ready), 32'(m_wrdy));
    check("x_ready", 32'(x_ready), 32'(m_xrdy));
  endtask

  task automatic idle_in();
    wt_valid = 1'b0;
    wt_in    = '0;
    x_valid  = 1'b0;
    x_in     = '0;
    x_last   = 1'b0;
  endtask

  task automatic load_w(logic [31:0] w0,
                        logic [31:0] w1,
                        logic [31:0] w2,
                        logic [31:0] w3);
    logic [31:0] w[4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      wt_valid = 1'b1;
      wt_in    = w[i];
      step();
      check("wt_seq", wt_arr, w[i]);
      check("ctrl_seq", 32'(control), 32'd1);
    end
    idle_in();
  endtask

  logic [31:0] tab[6];
  int          ctl_ones;

  initial begin
    idle_in();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_data", data_arr, 32'h0);
    check("rst_ctrl", 32'(control), 32'h0);
    check("rst_wt", wt_arr, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_wrdy", 32'(wt_ready), 32'h0);
    check("rst_xrdy", 32'(x_ready), 32'h0);
    rst_n = 1'b1;
    step();

    // full weight load, then one-row job
    load_w(32'h05020304, 32'h03010203,
           32'h07040102, 32'h01020403);
    check("wrdy_after", 32'(wt_ready), 32'h0);
    tab = '{32'h00000001, 32'h00000200,
            32'h00030000, 32'h04000000,
            32'h0, 32'h0};
    x_valid = 1'b1;
    x_in    = 32'h04030201;
    x_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      idle_in();
      check("row1", data_arr, tab[i]);
      check("row1_done", 32'(done),
            32'(i == 3));
    end

    // new load starts in the done cycle
    load_w(32'h11111111, 32'h22222222,
           32'h33333333, 32'h44444444);
    tab = '{32'h00000001, 32'h00000205,
            32'h00030600, 32'h04070000,
            32'h08000000, 32'h0};
    x_valid = 1'b1;
    x_in    = 32'h04030201;
    step();
    check("row2", data_arr, tab[0]);
    x_in   = 32'h08070605;
    x_last = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      idle_in();
      check("row2", data_arr, tab[i]);
    end
    check("row2_done", 32'(done), 32'd1);

    // bubble between two rows
    load_w(32'h01010101, 32'h02020202,
           32'h03030303, 32'h04040404);
    tab = '{32'h00000001, 32'h00000200,
            32'h00030005, 32'h04000600,
            32'h00070000, 32'h08000000};
    x_valid = 1'b1;
    x_in    = 32'h04030201;
    step();
    check("bub", data_arr, tab[0]);
    idle_in();
    step();
    check("bub", data_arr, tab[1]);
    x_valid = 1'b1;
    x_in    = 32'h08070605;
    x_last  = 1'b1;
    for (int i = 2; i < 6; i++) begin
      step();
      idle_in();
      check("bub", data_arr, tab[i]);
    end

    // gapped weights with activations offered
    ctl_ones = 0;
    for (int i = 0; i < 7; i++) begin
      wt_valid = (i % 2 == 0);
      wt_in    = 32'hA0A0A0A0 + 32'(i);
      x_valid  = 1'b1;
      x_in     = 32'hDEADBEEF;
      step();
      check("gap_ctrl", 32'(control),
            32'(i % 2 == 0));
      check("gap_noacc", data_arr, 32'h0);
      ctl_ones += int'(control);
    end
    check("gap_ones", 32'(ctl_ones), 32'd4);
    check("gap_xrdy", 32'(x_ready), 32'd1);

    // one row accepted, then reset mid-stream
    x_in   = 32'h0C0B0A09;
    x_last = 1'b0;
    wt_valid = 1'b0;
    step();
    idle_in();
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_data", data_arr, 32'h0);
    check("mid_ctrl", 32'(control), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_wrdy", 32'(wt_ready), 32'd1);
    check("post_xrdy", 32'(x_ready), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      wt_valid = ($urandom_range(1, 0) == 1);
      wt_in    = $urandom;
      x_valid  = ($urandom_range(3, 0) != 0);
      x_in     = $urandom;
      x_last   = ($urandom_range(3, 0) == 0);
      step();
    end
    idle_in();
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmu_feeder.md
# mmu_feeder

Upstream feeder for the 4x4 systolic `MMU`. It accepts the weight matrix as row beats and drives `control`/`wt_arr` to load the array. It then accepts unskewed activation rows and emits them diagonally skewed on `data_arr`, with byte lane k delayed k cycles. After the last row it flushes zeros until the skew drains, then pulses `done`.

## Interface
- `LANES`, 4, array dimension; number of byte lanes per beat
- `DW`, 8, bits per lane element
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `wt_valid`  in  1  weight beat valid
- `wt_ready`  out  1  weight beat accepted when `wt_valid && wt_ready`
- `wt_in`  in  LANES*DW  one weight row
- `x_valid`  in  1  activation beat valid
- `x_ready`  out  1  activation beat accepted when `x_valid && x_ready`
- `x_in`  in  LANES*DW  one unskewed activation row; lane k = bits [k*DW +: DW], lane 0 = LSB
- `x_last`  in  1  marks the final activation beat of the job
- `control`  out  1  to `MMU.control`; 1 = weight shift this cycle
- `wt_arr`  out  LANES*DW  to `MMU.wt_arr`
- `data_arr`  out  LANES*DW  to `MMU.data_arr`, skewed
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse when the skew has drained

## Operation
- The FSM has four states: IDLE, LOAD_WT, STREAM, FLUSH.
- **Reset:** all outputs are 0, all delay stages are 0, the weight counter is 0, and the state is IDLE.
- **IDLE and LOAD_WT**
  - `wt_ready`=1 and `x_ready`=0.
  - An accepted weight beat moves IDLE to LOAD_WT and increments the weight counter.
  - On the LANES-th accepted beat, the counter clears and the state moves to STREAM.
- **control / wt_arr**
  - Both are registered.
  - On the cycle after an accepted weight beat: `control`=1 and `wt_arr`=that beat.
  - On any other cycle: `control`=0 and `wt_arr` holds its last value.
  - Gaps in `wt_valid` produce `control`=0 cycles. MMU shifts weights only when `control`=1.
- **STREAM**
  - `x_ready`=1 and `wt_ready`=0.
  - An accepted beat feeds its lanes into the delay lines.
  - A cycle with no accepted beat feeds zeros (a bubble row).
  - An accepted beat with `x_last`=1 moves the state to FLUSH.
- **FLUSH**
  - `x_ready`=0, `wt_ready`=0, and zeros are fed to the delay lines.
  - FLUSH lasts exactly LANES-1 cycles, then the state returns to IDLE and `done` pulses for one cycle.
- **Skew**
  - Lane k has k+1 registers, so its input reaches `data_arr` k+1 cycles after it is fed.
  - `data_arr` is fully registered. No combinational path runs from any input to any output.
- **Boundaries**
  - `wt_valid` outside IDLE/LOAD_WT, and `x_valid` outside STREAM, are ignored (not accepted).
  - `x_last` on the first activation beat is legal: a one-row job.
  - A new weight load may begin in the same cycle `done` is high.
  - `rst_n` asserted mid-job immediately clears all state and outputs. Partial jobs are discarded.
  - `x_last` with `x_valid`=0 has no effect.
- No backpressure comes from the MMU side.

## Timing
- A weight beat accepted at edge t gives `control`=1 and `wt_arr`=beat in cycle t+1.
- An activation beat accepted at edge t:
  - Lane k appears on `data_arr` in cycle t+1+k.
  - Lane LANES-1 appears at t+LANES.
- If `x_last` is accepted at edge t:
  - FLUSH covers cycles t+1..t+LANES-1.
  - `done`=1 and the state is IDLE in cycle t+LANES, coincident with the final lane of the last row.
- Throughput is one activation row per cycle, with no inserted bubbles.

## Structure
- Shared package `mmu_pkg`: `LANES`, `DW`, the state encoding (IDLE=0, LOAD_WT=1, STREAM=2, FLUSH=3), and the lane-slice helper width `LANES*DW`.
- Sub-module `skew_delay`, parameterized by `DEPTH` and `DW`: a reset-to-zero shift register. One instance per lane, with DEPTH=k+1.
- The top holds the FSM, the weight counter, the flush counter, and the `control`/`wt_arr` registers.

## Test plan
- **Weight load:** beats 05020304, 03010203, 07040102, 01020403 on consecutive cycles.
  - `control`=1 for exactly 4 cycles, with `wt_arr` equal to those values in order.
  - State reaches STREAM, and `wt_ready`=0 afterwards.
- **One-row job:** after the weight load, send row 04030201 with `x_last`=1 at edge t.
  - `data_arr` = 00000001, 00000200, 00030000, 04000000 in cycles t+1..t+4.
  - `done`=1 only in cycle t+4.
- **Two back-to-back rows:** 04030201 then 08070605 (with `x_last`).
  - `data_arr` = 00000001, 00000205, 00030600, 04070000, 08000000.
  - `done` is high with the last of these.
- **Bubble:** rows 04030201, an idle cycle, then 08070605.
  - `data_arr` = 00000001, 00000200, 00030005, 04000600, 00070000, 08000000.
- **Gapped weights:** `wt_valid` toggles 1,0,1,0,...
  - `control` pattern is 1,0,1,0,1,0,1.
  - No activation beat is accepted until the 4th weight is accepted.
- **Reset mid-STREAM:** `rst_n`=0 after one accepted row.
  - `data_arr`, `control`, `busy` and `done` are all 0 immediately, and the state is IDLE.
  - After release, `x_ready`=0 and `wt_ready`=1.
